// File: rtl/cic_v4_pkg.sv
// Shared widths and arithmetic helpers for the multi-channel CIC decimator.
// Defaults describe the phasemeter front-end build of the block.
package cic_v4_pkg;

    localparam int DEF_N     = 3;
    localparam int DEF_R_MAX = 16;
    localparam int DEF_IN_W  = 14;
    localparam int DEF_OUT_W = 16;

    // Working width of the rounding/clamping helper; covers the widest legal accumulator.
    localparam int MAX_W = 128;

    function automatic int acc_w(input int in_w, input int n, input int r_max);
        return in_w + n * $clog2(r_max);
    endfunction

    localparam int RW = $clog2(DEF_R_MAX + 1);
    localparam int SW = $clog2(acc_w(DEF_IN_W, DEF_N, DEF_R_MAX));

    typedef struct packed {
        logic signed [MAX_W-1:0] value;
        logic                    sat;
    } rs_t;

    // Arithmetic shift with round-half-up, then clamp to a signed out_w range.
    function automatic rs_t round_sat(input logic signed [MAX_W-1:0] value,
                                      input int shift, input int out_w);
        logic signed [MAX_W-1:0] half;
        logic signed [MAX_W-1:0] v;
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        rs_t r;
        half = (shift > 0) ? (MAX_W'(1) << (shift - 1)) : '0;
        v = (value + half) >>> shift;
        hi = (MAX_W'(1) << (out_w - 1)) - MAX_W'(1);
        lo = ~hi;
        r.sat = (v > hi) || (v < lo);
        r.value = (v > hi) ? hi : ((v < lo) ? lo : v);
        return r;
    endfunction

endpackage

// File: rtl/cic_lane_v4.sv
// One lane of the CIC decimator: integrator chain, comb chain and output rounding.
// Every stage advances only on the valid/decimate tags supplied by the control path.
module cic_lane_v4 import cic_v4_pkg::*; #(
    parameter int N       = 3,
    parameter int IN_W    = 14,
    parameter int OUT_W   = 16,
    parameter int ACC_W   = 26,
    parameter int SHIFT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               take,
    input  logic [IN_W-1:0]    in_data,
    input  logic [N-1:0]       int_tag,
    input  logic [N-1:0]       comb_tag,
    input  logic               out_load,
    input  logic [SHIFT_W-1:0] shift,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_sat
);

    logic signed [ACC_W-1:0] x_reg;
    logic signed [ACC_W-1:0] integ    [N];
    logic signed [ACC_W-1:0] integ_in [N];
    logic signed [ACC_W-1:0] comb     [N];
    logic signed [ACC_W-1:0] comb_in  [N];
    logic signed [ACC_W-1:0] dly      [N];
    rs_t  rs;
    logic unused_hi;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            integ_in[k] = '0;
            comb_in[k]  = '0;
        end
        integ_in[0] = x_reg;
        comb_in[0]  = integ[N-1];
        for (int k = 1; k < N; k++) begin
            integ_in[k] = integ[k-1];
            comb_in[k]  = comb[k-1];
        end
    end

    always_comb rs = round_sat({{(MAX_W-ACC_W){comb[N-1][ACC_W-1]}}, comb[N-1]}, int'(shift), OUT_W);

    // Clamped value always fits OUT_W; the upper bits are sign copies.
    assign unused_hi = ^rs.value[MAX_W-1:OUT_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg <= '0;
            for (int k = 0; k < N; k++) begin
                integ[k] <= '0;
                comb[k]  <= '0;
                dly[k]   <= '0;
            end
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (flush) begin
            x_reg <= '0;
            for (int k = 0; k < N; k++) begin
                integ[k] <= '0;
                comb[k]  <= '0;
                dly[k]   <= '0;
            end
        end else begin
            if (take) x_reg <= {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
            for (int k = 0; k < N; k++) begin
                if (int_tag[k]) integ[k] <= integ[k] + integ_in[k];
                if (comb_tag[k]) begin
                    comb[k] <= comb_in[k] - dly[k];
                    dly[k]  <= comb_in[k];
                end
            end
            if (out_load) begin
                out_data <= rs.value[OUT_W-1:0];
                out_sat  <= rs.sat;
            end
        end
    end

endmodule

// File: rtl/cic_decim_v4.sv
// Multi-channel CIC decimator: shared config, rate counter and tag pipeline
// steering NUM_CH lock-step lanes, with warm-up suppression of early outputs.
module cic_decim_v4 import cic_v4_pkg::*; #(
    parameter int N      = 3,
    parameter int R_MAX  = 16,
    parameter int IN_W   = 14,
    parameter int OUT_W  = 16,
    parameter int NUM_CH = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       cfg_load,
    input  logic [$clog2(R_MAX+1)-1:0]                 cfg_rate,
    input  logic [$clog2(acc_w(IN_W, N, R_MAX))-1:0]   cfg_shift,
    output logic                                       cfg_err,
    input  logic                                       s_valid,
    input  logic [NUM_CH*IN_W-1:0]                     s_data,
    output logic                                       m_valid,
    output logic [NUM_CH*OUT_W-1:0]                    m_data,
    output logic [NUM_CH-1:0]                          m_sat
);

    localparam int ACC_W   = acc_w(IN_W, N, R_MAX);
    localparam int RATE_W  = $clog2(R_MAX + 1);
    localparam int SHIFT_W = $clog2(ACC_W);
    localparam int SH_RST  = (ACC_W > OUT_W) ? ACC_W - OUT_W : 0;
    localparam int WARM_W  = $clog2(N + 1);
    localparam int DT_W    = 2 * N + 1;

    logic [RATE_W-1:0]  rate;
    logic [RATE_W-1:0]  cnt;
    logic [SHIFT_W-1:0] shift;
    logic [WARM_W-1:0]  warm;
    logic [N-1:0]       vtag;
    logic [DT_W-1:0]    dtag;
    logic               cfg_ok;
    logic               accept;
    logic               take;
    logic               dec;
    logic               out_load;

    // Input is always ready: a sample is consumed on every cycle s_valid is high,
    // except when an accepted cfg_load in the same cycle flushes the datapath.
    assign cfg_ok   = (cfg_rate >= RATE_W'(2)) && (cfg_rate <= RATE_W'(R_MAX))
                   && (cfg_shift <= SHIFT_W'(ACC_W - 1));
    assign accept   = cfg_load && cfg_ok;
    assign take     = s_valid && !accept;
    assign dec      = take && (cnt == rate - 1'b1);
    assign out_load = dtag[2*N] && (warm == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rate    <= RATE_W'(R_MAX);
            shift   <= SHIFT_W'(SH_RST);
            cnt     <= '0;
            vtag    <= '0;
            dtag    <= '0;
            warm    <= WARM_W'(N);
            m_valid <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_load && !cfg_ok;
            if (accept) begin
                rate    <= cfg_rate;
                shift   <= cfg_shift;
                cnt     <= '0;
                vtag    <= '0;
                dtag    <= '0;
                warm    <= WARM_W'(N);
                m_valid <= 1'b0;
            end else begin
                if (take) cnt <= dec ? '0 : cnt + 1'b1;
                vtag    <= N'({vtag, take});
                dtag    <= DT_W'({dtag, dec});
                m_valid <= out_load;
                if (dtag[2*N] && (warm != '0)) warm <= warm - 1'b1;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        cic_lane_v4 #(
            .N(N), .IN_W(IN_W), .OUT_W(OUT_W), .ACC_W(ACC_W), .SHIFT_W(SHIFT_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .flush    (accept),
            .take     (take),
            .in_data  (s_data[c*IN_W +: IN_W]),
            .int_tag  (vtag),
            .comb_tag (dtag[2*N-1:N]),
            .out_load (out_load),
            .shift    (shift),
            .out_data (m_data[c*OUT_W +: OUT_W]),
            .out_sat  (m_sat[c])
        );
    end

endmodule

// File: tb/tb_cic_decim_v4.sv
// Directed bench for cic_decim_v4 at N=3, R_MAX=16, IN_W=14, OUT_W=16, two lanes.
// Output strobes are logged with their cycle offset and checked against hand-derived streams.
module tb_cic_decim_v4;
    import cic_v4_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_load;
    logic [RW-1:0] cfg_rate;
    logic [SW-1:0] cfg_shift;
    logic          cfg_err;
    logic          s_valid;
    logic [27:0]   s_data;
    logic          m_valid;
    logic [31:0]   m_data;
    logic [1:0]    m_sat;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;
    int rec_cyc[$];
    int rec_d0[$];
    int rec_d1[$];
    int rec_sat[$];

    always #5 clk = ~clk;

    cic_decim_v4 #(
        .N(3), .R_MAX(16), .IN_W(14), .OUT_W(16), .NUM_CH(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_load  (cfg_load),
        .cfg_rate  (cfg_rate),
        .cfg_shift (cfg_shift),
        .cfg_err   (cfg_err),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_sat     (m_sat)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (m_valid) begin
            rec_cyc.push_back(cyc - t0);
            rec_d0.push_back(int'($signed(m_data[15:0])));
            rec_d1.push_back(int'($signed(m_data[31:16])));
            rec_sat.push_back(int'(m_sat));
        end
    endtask

    task automatic mark();
        t0 = cyc;
        rec_cyc.delete();
        rec_d0.delete();
        rec_d1.delete();
        rec_sat.delete();
    endtask

    task automatic set_data(input int d0, input int d1);
        logic [13:0] a;
        logic [13:0] b;
        a = 14'(d0);
        b = 14'(d1);
        s_data = {b, a};
    endtask

    task automatic load(input int rate, input int shift, input logic valid);
        cfg_rate  = RW'(rate);
        cfg_shift = SW'(shift);
        cfg_load  = 1'b1;
        s_valid   = valid;
        tick();
        cfg_load  = 1'b0;
        s_valid   = 1'b0;
    endtask

    task automatic run_valid(input int n, input int period);
        for (int i = 0; i < n; i++) begin
            s_valid = ((i % period) == 0);
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic check_stream(input string tag, input int count, input int first,
                                input int period, input int e0, input int e1, input int esat);
        chk({tag, " count"}, rec_cyc.size(), count);
        for (int i = 0; i < rec_cyc.size() && i < count; i++) begin
            chk($sformatf("%s out%0d cycle", tag, i), rec_cyc[i], first + i * period);
            chk($sformatf("%s out%0d lane0", tag, i), rec_d0[i], e0);
            chk($sformatf("%s out%0d lane1", tag, i), rec_d1[i], e1);
            chk($sformatf("%s out%0d sat", tag, i), rec_sat[i], esat);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cfg_load = 1'b0;
        cfg_rate = '0;
        cfg_shift = '0;
        s_valid = 1'b0;
        s_data = '0;
        tick();
        tick();
        chk("reset m_valid", int'(m_valid), 0);
        chk("reset m_data", int'(m_data), 0);
        chk("reset m_sat", int'(m_sat), 0);
        chk("reset cfg_err", int'(cfg_err), 0);

        // Defaults rate 16, shift 10: gain 4096/1024, first output after block 4, 7 cycles late
        set_data(1000, -1000);
        rst = 1'b0;
        mark();
        run_valid(110, 1);
        check_stream("dflt", 3, 71, 16, 4000, -4000, 0);

        // rate 8, shift 7: gain 512/128
        load(8, 7, 1'b1);
        mark();
        run_valid(60, 1);
        check_stream("r8", 3, 39, 8, 4000, -4000, 0);

        // One valid in three: 64th sample lands on cycle 190, output 7 cycles on
        load(16, 10, 1'b0);
        mark();
        run_valid(250, 3);
        check_stream("gaps", 2, 197, 48, 4000, -4000, 0);

        // Full-scale DC at rate 16, shift 8 overflows 16 bits on both lanes
        load(16, 8, 1'b0);
        set_data(8191, -8192);
        mark();
        run_valid(75, 1);
        check_stream("sat", 1, 71, 16, 32767, -32768, 3);

        // rate 2, shift 4: +8 rounds to 1, -8 rounds to 0
        load(2, 4, 1'b0);
        set_data(1, -1);
        mark();
        run_valid(20, 1);
        check_stream("rnd", 3, 15, 2, 1, 0, 0);

        // Rejected loads in a running stream
        mark();
        run_valid(2, 1);
        load(1, 4, 1'b1);
        chk("rate1 cfg_err", int'(cfg_err), 1);
        run_valid(1, 1);
        chk("rate1 cfg_err clear", int'(cfg_err), 0);
        load(17, 4, 1'b1);
        chk("rate17 cfg_err", int'(cfg_err), 1);
        run_valid(1, 1);
        chk("rate17 cfg_err clear", int'(cfg_err), 0);
        load(2, 26, 1'b1);
        chk("shift26 cfg_err", int'(cfg_err), 1);
        run_valid(1, 1);
        chk("shift26 cfg_err clear", int'(cfg_err), 0);
        run_valid(2, 1);
        check_stream("rej", 5, 1, 2, 1, 0, 0);

        // Asynchronous reset while an output is being presented
        run_valid(1, 1);
        chk("pre-rst m_valid", int'(m_valid), 1);
        chk("pre-rst m_data", int'(m_data), 1);
        rst = 1'b1;
        #1;
        chk("async rst m_valid", int'(m_valid), 0);
        chk("async rst m_data", int'(m_data), 0);
        chk("async rst m_sat", int'(m_sat), 0);
        tick();
        tick();
        rst = 1'b0;
        set_data(1000, -1000);
        mark();
        run_valid(75, 1);
        check_stream("post-rst", 1, 71, 16, 4000, -4000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
